// File: rtl/uart_byte_rx_if.sv
// Byte-side bundle of the UART receiver: the serial line in, the decoded
// byte and its strobes out. The slave side is the receiver itself; the
// master side is whatever drives the line and consumes the bytes.
interface uart_byte_rx_if;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;

  modport master (
    output rx,
    input  po_data,
    input  po_flag,
    input  frame_err
  );

  modport slave (
    input  rx,
    output po_data,
    output po_flag,
    output frame_err
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver. Synchronises the rx pin, finds the start edge, takes a
// 2-of-3 majority vote around mid-bit for every bit, and presents each good
// byte as a one-cycle po_flag with po_data held until the next good byte.
// A low stop bit gives a one-cycle frame_err, then the receiver waits for the
// line to return high so a break yields exactly one error.
// BAUD_CNT (CLK_FREQ / UART_BPS) must be at least 8.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  uart_byte_rx_if.slave bus
);

  localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int HALF     = BAUD_CNT / 2;
  localparam int CNT_W    = $clog2(BAUD_CNT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;

  logic             rx_m, rx_s, rx_d;
  logic [1:0]       flush;
  logic             line_ok;
  logic [1:0]       smp;
  logic             maj;
  logic             dec;
  logic             data_wr;
  logic             good_stop;
  logic             bad_stop;
  logic [7:0]       shreg;
  logic [7:0]       po_data_r;
  logic             po_flag_r;
  logic             frame_err_r;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  // All three idle high so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Arm start detection only after the synchroniser holds real pin values
  // and the line has been seen high, so a line already low when reset lifts
  // is never mistaken for a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flush   <= 2'd0;
      line_ok <= 1'b0;
    end else begin
      if (flush != 2'd3) flush <= flush + 2'd1;
      if (flush == 2'd3 && rx_s) line_ok <= 1'b1;
    end
  end

  // Majority of the two stored mid-bit samples and the current one; only
  // consumed on the decision cycle cnt == HALF+1.
  assign maj = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign dec = (cnt == CNT_DEC);

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
    end
  end

  // FSM next-state, bit timing and decision strobes.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    data_wr    = 1'b0;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx     = '0;
        bit_idx_nx = 3'd0;
        // The edge-detect cycle itself is count 0 of the start bit.
        if (line_ok && rx_d && !rx_s) begin
          state_nx = START;
          cnt_nx   = CNT_W'(1);
        end
      end
      START: begin
        cnt_nx = cnt + 1'b1;
        if (dec && maj) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = DATA;
          cnt_nx     = '0;
          bit_idx_nx = 3'd0;
        end
      end
      DATA: begin
        cnt_nx  = cnt + 1'b1;
        data_wr = dec;
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_idx_nx = bit_idx + 3'd1;
        end
      end
      STOP: begin
        cnt_nx = cnt + 1'b1;
        // Leave at mid-stop so a start edge right at the frame end is caught.
        if (dec) begin
          cnt_nx     = '0;
          bit_idx_nx = 3'd0;
          if (maj) begin
            good_stop = 1'b1;
            state_nx  = IDLE;
          end else begin
            bad_stop  = 1'b1;
            state_nx  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Capture the two early mid-bit samples for the vote.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      smp <= 2'b00;
    end else begin
      if (cnt == CNT_S0) smp[0] <= rx_s;
      if (cnt == CNT_S1) smp[1] <= rx_s;
    end
  end

  // Shift in data bits LSB first; publish the byte together with po_flag so
  // po_data only ever changes on the strobe cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shreg       <= 8'h00;
      po_data_r   <= 8'h00;
      po_flag_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      po_flag_r   <= good_stop;
      frame_err_r <= bad_stop;
      if (data_wr)   shreg[bit_idx] <= maj;
      if (good_stop) po_data_r      <= shreg;
    end
  end

  assign bus.po_data   = po_data_r;
  assign bus.po_flag   = po_flag_r;
  assign bus.frame_err = frame_err_r;

endmodule
